// File: rtl/fma16_ctrl.sv
// Sequencing controller for the half-precision FMA datapath: decodes one op at a time,
// holds datapath controls for LATENCY cycles, buffers the result and keeps sticky fflags.
module fma16_ctrl #(
    parameter  int unsigned LATENCY = 1,
    localparam int unsigned DataW   = 16,
    localparam int unsigned FlagW   = 4,
    localparam int unsigned OpW     = 3,
    localparam int unsigned RmW     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OpW-1:0]   req_op,
    input  logic [DataW-1:0] req_x,
    input  logic [DataW-1:0] req_y,
    input  logic [DataW-1:0] req_z,
    input  logic [RmW-1:0]   req_rm,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [DataW-1:0] resp_result,
    output logic [FlagW-1:0] resp_flags,
    output logic [DataW-1:0] dp_x,
    output logic [DataW-1:0] dp_y,
    output logic [DataW-1:0] dp_z,
    output logic             dp_mul,
    output logic             dp_add,
    output logic             dp_negp,
    output logic             dp_negz,
    output logic [RmW-1:0]   dp_rm,
    input  logic [DataW-1:0] dp_result,
    input  logic [FlagW-1:0] dp_flags,
    output logic [FlagW-1:0] fflags,
    input  logic             fflags_clr,
    output logic             busy
);

    localparam int unsigned CntW = 4;

    localparam logic [DataW-1:0] OneHalf  = 16'h3C00;
    localparam logic [DataW-1:0] CanonNan = 16'h7E00;
    localparam logic [FlagW-1:0] FlagNv   = 4'b1000;

    localparam logic [OpW-1:0] OpFmul   = 3'b000;
    localparam logic [OpW-1:0] OpFadd   = 3'b001;
    localparam logic [OpW-1:0] OpFmadd  = 3'b010;
    localparam logic [OpW-1:0] OpFmsub  = 3'b011;
    localparam logic [OpW-1:0] OpFnmadd = 3'b100;
    localparam logic [OpW-1:0] OpFnmsub = 3'b101;

    typedef struct packed {
        logic [DataW-1:0] x;
        logic [DataW-1:0] y;
        logic [DataW-1:0] z;
        logic             mul;
        logic             add;
        logic             negp;
        logic             negz;
        logic [RmW-1:0]   rm;
    } dpCtrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, stateNext;
    logic [CntW-1:0]  cnt, cntNext;
    dpCtrl_t          dpQ, dpNext;
    logic [DataW-1:0] resultQ, resultNext;
    logic [FlagW-1:0] flagsQ, flagsNext;
    logic [FlagW-1:0] fflagsQ, fflagsNext;

    dpCtrl_t          decoded;
    logic             legal;
    logic             readyC;
    logic             acceptC;
    logic             capture;

    assign readyC  = (state == IDLE) || ((state == RESP) && resp_ready);
    assign acceptC = req_valid && readyC;

    // Opcode to datapath control decode; FMUL zeroes z, FADD forces y to 1.0.
    always_comb begin
        decoded.x    = req_x;
        decoded.y    = req_y;
        decoded.z    = req_z;
        decoded.mul  = 1'b1;
        decoded.add  = 1'b1;
        decoded.negp = 1'b0;
        decoded.negz = 1'b0;
        decoded.rm   = req_rm;
        legal        = 1'b1;
        case (req_op)
            OpFmul: begin
                decoded.z   = '0;
                decoded.add = 1'b0;
            end
            OpFadd: begin
                decoded.y   = OneHalf;
                decoded.mul = 1'b0;
            end
            OpFmadd: ;
            OpFmsub:  decoded.negz = 1'b1;
            OpFnmadd: begin
                decoded.negp = 1'b1;
                decoded.negz = 1'b1;
            end
            OpFnmsub: decoded.negp = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    // Next-state and register-update logic.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        dpNext     = dpQ;
        resultNext = resultQ;
        flagsNext  = flagsQ;
        capture    = 1'b0;
        fflagsNext = fflagsQ;

        case (state)
            IDLE, RESP: begin
                if (acceptC) begin
                    if (legal) begin
                        dpNext    = decoded;
                        cntNext   = CntW'(LATENCY);
                        stateNext = BUSY;
                    end else begin
                        resultNext = CanonNan;
                        flagsNext  = FlagNv;
                        capture    = 1'b1;
                        stateNext  = RESP;
                    end
                end else if ((state == RESP) && resp_ready) begin
                    stateNext = IDLE;
                end
            end
            BUSY: begin
                if (cnt > 4'd1) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    resultNext = dp_result;
                    flagsNext  = dp_flags;
                    capture    = 1'b1;
                    stateNext  = RESP;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Clear applies before accumulating a same-cycle capture.
        if (capture) begin
            fflagsNext = (fflags_clr ? '0 : fflagsQ) | flagsNext;
        end else if (fflags_clr) begin
            fflagsNext = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dpQ     <= '0;
            resultQ <= '0;
            flagsQ  <= '0;
            fflagsQ <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            dpQ     <= dpNext;
            resultQ <= resultNext;
            flagsQ  <= flagsNext;
            fflagsQ <= fflagsNext;
        end
    end

    assign req_ready   = readyC;
    assign resp_valid  = (state == RESP);
    assign busy        = (state != IDLE);
    assign resp_result = resultQ;
    assign resp_flags  = flagsQ;
    assign fflags      = fflagsQ;
    assign dp_x        = dpQ.x;
    assign dp_y        = dpQ.y;
    assign dp_z        = dpQ.z;
    assign dp_mul      = dpQ.mul;
    assign dp_add      = dpQ.add;
    assign dp_negp     = dpQ.negp;
    assign dp_negz     = dpQ.negz;
    assign dp_rm       = dpQ.rm;

endmodule

// File: tb/tb_fma16_ctrl.sv
// Randomized bench for fma16_ctrl: emulates a LATENCY-cycle datapath with real arithmetic
// and checks handshake timing, decode, results and sticky flags against a transaction model.
module tb_fma16_ctrl;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_x, req_y, req_z;
    logic [1:0]  req_rm;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_result;
    logic [3:0]  resp_flags;
    logic [15:0] dp_x, dp_y, dp_z;
    logic        dp_mul, dp_add, dp_negp, dp_negz;
    logic [1:0]  dp_rm;
    logic [15:0] dp_result;
    logic [3:0]  dp_flags;
    logic [3:0]  fflags;
    logic        fflags_clr;
    logic        busy;

    fma16_ctrl #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rm(req_rm),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
        .dp_mul(dp_mul), .dp_add(dp_add), .dp_negp(dp_negp), .dp_negz(dp_negz),
        .dp_rm(dp_rm), .dp_result(dp_result), .dp_flags(dp_flags),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        int  e;
        real m, v;
        e = int'(h[14:10]);
        m = real'(h[9:0]) / 1024.0;
        if (e == 0) v = m * (2.0 ** real'(-14));
        else        v = (1.0 + m) * (2.0 ** real'(e - 15));
        return h[15] ? -v : v;
    endfunction

    // Exact conversion; stimulus operands keep every result representable.
    function automatic logic [15:0] r2h(input real r);
        real  a;
        int   e;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        return {s, 5'(e), 10'($rtoi((a - 1.0) * 1024.0))};
    endfunction

    function automatic logic [15:0] dpEval(input logic [15:0] x, y, z,
                                           input logic mul, add, negp, negz);
        real p, s;
        p = mul ? h2r(x) * h2r(y) : h2r(x);
        s = add ? h2r(z) : 0.0;
        if (negp) p = -p;
        if (negz) s = -s;
        return r2h(p + s);
    endfunction

    function automatic logic [15:0] refResult(input logic [2:0] op, input logic [15:0] x, y, z);
        real a, b, c, r;
        a = h2r(x); b = h2r(y); c = h2r(z);
        case (op)
            3'd0:    r = a * b;
            3'd1:    r = a + c;
            3'd2:    r = a * b + c;
            3'd3:    r = a * b - c;
            3'd4:    r = -(a * b) - c;
            default: r = -(a * b) + c;
        endcase
        return r2h(r);
    endfunction

    function automatic logic [53:0] refDp(input logic [2:0] op, input logic [15:0] x, y, z,
                                          input logic [1:0] rm);
        return {x, (op == 3'd1) ? 16'h3C00 : y, (op == 3'd0) ? 16'h0000 : z,
                op != 3'd1, op != 3'd0, (op == 3'd4) || (op == 3'd5),
                (op == 3'd3) || (op == 3'd4), rm};
    endfunction

    function automatic logic [53:0] dpNow();
        return {dp_x, dp_y, dp_z, dp_mul, dp_add, dp_negp, dp_negz, dp_rm};
    endfunction

    // Emulated datapath: garbage until LAT edges after issue have elapsed.
    logic [4:0] age = 5'd31;
    logic [3:0] opFlags = 4'd0;

    always @(posedge clk) begin
        if (req_valid && req_ready) age <= 5'd0;
        else if (age != 5'd31)      age <= age + 5'd1;
    end

    always_comb begin
        if (age >= 5'(LAT - 1)) begin
            dp_result = dpEval(dp_x, dp_y, dp_z, dp_mul, dp_add, dp_negp, dp_negz);
            dp_flags  = opFlags;
        end else begin
            dp_result = 16'hDEAD;
            dp_flags  = ~opFlags;
        end
    end

    logic [53:0] expDp  = '0;
    logic [3:0]  sticky = '0;
    bit          inResp = 0;
    logic [15:0] vals [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                              16'hBC00, 16'h3800, 16'h0000, 16'hC000};

    // Entered just after a negedge; leaves the response held with resp_ready low.
    task automatic runOp(input logic [2:0] op, input logic [15:0] x, y, z,
                         input logic [1:0] rm, input logic [3:0] fl, input bit clr,
                         input int stall);
        logic [15:0] expRes;
        logic [3:0]  expFl;
        bit          legal;
        legal     = (op <= 3'd5);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_z = z; req_rm = rm;
        opFlags   = fl;
        if (inResp) resp_ready = 1'b1;
        if (!legal) fflags_clr = clr;
        #1;
        checkVal("req_ready_accept", 64'(req_ready), 64'(1));
        @(posedge clk);
        if (legal) expDp = refDp(op, x, y, z, rm);
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        #1;
        if (legal) begin
            expRes = refResult(op, x, y, z);
            expFl  = fl;
            for (int i = 0; i < LAT; i++) begin
                checkVal("busy_inflight", 64'(busy), 64'(1));
                checkVal("resp_valid_early", 64'(resp_valid), 64'(0));
                checkVal("req_ready_busy", 64'(req_ready), 64'(0));
                checkVal("dp_hold", 64'(dpNow()), 64'(expDp));
                if (i == LAT - 1) fflags_clr = clr;
                @(posedge clk);
                @(negedge clk);
            end
            fflags_clr = 1'b0;
            #1;
        end else begin
            expRes     = 16'h7E00;
            expFl      = 4'b1000;
            fflags_clr = 1'b0;
        end
        sticky = clr ? expFl : (sticky | expFl);
        checkVal("resp_valid", 64'(resp_valid), 64'(1));
        checkVal("resp_result", 64'(resp_result), 64'(expRes));
        checkVal("resp_flags", 64'(resp_flags), 64'(expFl));
        checkVal("fflags", 64'(fflags), 64'(sticky));
        checkVal("dp_after", 64'(dpNow()), 64'(expDp));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkVal("stall_valid", 64'(resp_valid), 64'(1));
            checkVal("stall_result", 64'(resp_result), 64'(expRes));
            checkVal("stall_flags", 64'(resp_flags), 64'(expFl));
            checkVal("stall_ready", 64'(req_ready), 64'(0));
        end
        inResp = 1;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        checkVal("drain_busy", 64'(busy), 64'(0));
        checkVal("drain_valid", 64'(resp_valid), 64'(0));
        checkVal("drain_ready", 64'(req_ready), 64'(1));
        inResp = 0;
    endtask

    task automatic idleClr();
        fflags_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fflags_clr = 1'b0;
        sticky = '0;
        #1;
        checkVal("idle_clr", 64'(fflags), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0; req_z = '0;
        req_rm = '0; resp_ready = 1'b0; fflags_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        checkVal("rst_busy", 64'(busy), 64'(0));
        checkVal("rst_valid", 64'(resp_valid), 64'(0));
        checkVal("rst_result", 64'(resp_result), 64'(0));
        checkVal("rst_flags", 64'(resp_flags), 64'(0));
        checkVal("rst_dp", 64'(dpNow()), 64'(0));
        checkVal("rst_fflags", 64'(fflags), 64'(0));
        checkVal("rst_ready", 64'(req_ready), 64'(1));
        reset = 1'b0;

        runOp(3'd2, 16'h3C00, 16'h4000, 16'h3C00, 2'd0, 4'b0000, 0, 0);
        checkVal("fmadd_lit", 64'(resp_result), 64'(16'h4200));
        runOp(3'd0, 16'h4000, 16'h4200, 16'h4400, 2'd1, 4'b0000, 0, 0);
        checkVal("fmul_lit", 64'(resp_result), 64'(16'h4600));
        checkVal("fmul_dpz", 64'(dp_z), 64'(0));
        runOp(3'd1, 16'h3C00, 16'h4400, 16'h3C00, 2'd2, 4'b0000, 0, 0);
        checkVal("fadd_lit", 64'(resp_result), 64'(16'h4000));
        checkVal("fadd_dpy", 64'(dp_y), 64'(16'h3C00));
        runOp(3'd7, 16'h1234, 16'h5678, 16'h9ABC, 2'd3, 4'b0000, 0, 2);
        checkVal("illegal_fflags_nv", 64'(fflags[3]), 64'(1));
        drain();
        idleClr();

        runOp(3'd3, 16'h4000, 16'h4000, 16'h3C00, 2'd0, 4'b0001, 0, 0);
        runOp(3'd4, 16'h3800, 16'h4000, 16'h3C00, 2'd0, 4'b0100, 0, 0);
        checkVal("sticky_0101", 64'(fflags), 64'(4'b0101));
        runOp(3'd5, 16'h4000, 16'h3C00, 16'h4400, 2'd1, 4'b0010, 1, 5);
        checkVal("sticky_clr_cap", 64'(fflags), 64'(4'b0010));
        runOp(3'd2, 16'h4200, 16'h4200, 16'hC000, 2'd0, 4'b0000, 0, 1);
        drain();
        idleClr();

        for (int n = 0; n < 80; n++) begin
            if (inResp && ($urandom % 2 == 0)) drain();
            if (!inResp && ($urandom % 6 == 0)) idleClr();
            runOp(3'($urandom_range(0, 7)), vals[$urandom_range(0, 7)], vals[$urandom_range(0, 7)],
                  vals[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  ($urandom % 4 == 0), int'($urandom_range(0, 4)));
        end
        if (inResp) drain();

        runOp(3'd7, 16'h0000, 16'h0000, 16'h0000, 2'd0, 4'b0000, 0, 0);
        drain();
        req_valid = 1'b1; req_op = 3'd2; req_x = 16'h4000; req_y = 16'h4000; req_z = 16'h3C00;
        req_rm = 2'd1; opFlags = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkVal("midrst_busy", 64'(busy), 64'(0));
        checkVal("midrst_valid", 64'(resp_valid), 64'(0));
        checkVal("midrst_dp", 64'(dpNow()), 64'(0));
        checkVal("midrst_fflags", 64'(fflags), 64'(0));
        checkVal("midrst_ready", 64'(req_ready), 64'(1));
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checkVal("dropped_no_resp", 64'(resp_valid), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
